// File: rtl/execute_stage.sv
// Execute stage: forwarding muxes, single-cycle ALU, iterative restoring divider
// for DIVU/REMU, and the registered EX/MEM pipeline register.
module execute_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] SRC_A,
    input  logic [XLEN-1:0] SRC_B,
    input  logic [XLEN-1:0] IMM,
    input  logic            ALU_SRC,
    input  logic [3:0]      ALU_OP,
    input  logic [1:0]      FWD_A,
    input  logic [1:0]      FWD_B,
    input  logic [XLEN-1:0] BP_MEM,
    input  logic [XLEN-1:0] BP_WB,
    input  logic            VALID_D,
    input  logic [4:0]      RD_D,
    input  logic            MEM_WE_D,
    input  logic            ME_WE_D,
    input  logic            MEM_REG_D,
    input  logic            FLUSH,
    output logic [XLEN-1:0] ALU_OUT,
    output logic [XLEN-1:0] WD_ME,
    output logic [4:0]      RD,
    output logic            MEM_WE,
    output logic            ME_WE,
    output logic            MEM_REG,
    output logic            STALL,
    output logic [1:0]      DBG_STATE
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res;
    logic            is_div, start;

    logic [XLEN-1:0] quo_q, rem_q, dvs_q, h_wd_q;
    logic [CW-1:0]   cnt_q;
    logic [4:0]      h_rd_q;
    logic            h_mem_we_q, h_me_we_q, h_mem_reg_q, h_rem_q;

    logic [XLEN:0]   trial;
    logic            ge;
    logic [XLEN-1:0] rem_n, quo_n;

    logic [XLEN-1:0] alu_out_q, alu_out_d, wd_me_q, wd_me_d;
    logic [4:0]      rd_q, rd_d;
    logic            mem_we_q, mem_we_d, me_we_q, me_we_d, mem_reg_q, mem_reg_d;

    always_comb begin
        fwd_a = SRC_A;
        case (FWD_A)
            2'b01:   fwd_a = BP_MEM;
            2'b10:   fwd_a = BP_WB;
            default: fwd_a = SRC_A;
        endcase
        fwd_b = SRC_B;
        case (FWD_B)
            2'b01:   fwd_b = BP_MEM;
            2'b10:   fwd_b = BP_WB;
            default: fwd_b = SRC_B;
        endcase
        op_b = ALU_SRC ? IMM : fwd_b;
    end

    always_comb begin
        alu_res = '0;
        case (ALU_OP)
            4'd0:    alu_res = fwd_a + op_b;
            4'd1:    alu_res = fwd_a - op_b;
            4'd2:    alu_res = fwd_a & op_b;
            4'd3:    alu_res = fwd_a | op_b;
            4'd4:    alu_res = fwd_a ^ op_b;
            4'd5:    alu_res = fwd_a << op_b[4:0];
            4'd6:    alu_res = fwd_a >> op_b[4:0];
            4'd7:    alu_res = $unsigned($signed(fwd_a) >>> op_b[4:0]);
            4'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
            4'd9:    alu_res = {{(XLEN-1){1'b0}}, fwd_a < op_b};
            4'd10:   alu_res = fwd_a * op_b;
            default: alu_res = '0;
        endcase
    end

    assign is_div = (ALU_OP == 4'd11) || (ALU_OP == 4'd12);
    assign start  = (state_q == S_IDLE) && VALID_D && is_div && !FLUSH;

    // Restoring step: shift the next dividend bit into the partial remainder and
    // subtract the divisor when it fits; the sign bit of trial says it did not.
    assign trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
    assign ge    = ~trial[XLEN];
    assign rem_n = ge ? trial[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    assign quo_n = {quo_q[XLEN-2:0], ge};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (VALID_D && is_div) state_d = S_BUSY;
            S_BUSY:  if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (FLUSH) state_d = S_IDLE;
    end

    always_comb begin
        STALL     = rst && !FLUSH &&
                    ((state_q == S_BUSY) || ((state_q == S_IDLE) && VALID_D && is_div));
        alu_out_d = '0;
        wd_me_d   = '0;
        rd_d      = '0;
        mem_we_d  = 1'b0;
        me_we_d   = 1'b0;
        mem_reg_d = 1'b0;
        if (!FLUSH) begin
            if ((state_q == S_IDLE) && VALID_D && !is_div) begin
                alu_out_d = alu_res;
                wd_me_d   = fwd_b;
                rd_d      = RD_D;
                mem_we_d  = MEM_WE_D;
                me_we_d   = ME_WE_D && (RD_D != 5'd0);
                mem_reg_d = MEM_REG_D;
            end else if (state_q == S_DONE) begin
                alu_out_d = h_rem_q ? rem_q : quo_q;
                wd_me_d   = h_wd_q;
                rd_d      = h_rd_q;
                mem_we_d  = h_mem_we_q;
                me_we_d   = h_me_we_q;
                mem_reg_d = h_mem_reg_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            h_wd_q      <= '0;
            h_rd_q      <= '0;
            h_mem_we_q  <= 1'b0;
            h_me_we_q   <= 1'b0;
            h_mem_reg_q <= 1'b0;
            h_rem_q     <= 1'b0;
        end else if (start) begin
            quo_q       <= fwd_a;
            dvs_q       <= op_b;
            rem_q       <= '0;
            cnt_q       <= CW'(XLEN - 1);
            h_wd_q      <= fwd_b;
            h_rd_q      <= RD_D;
            h_mem_we_q  <= MEM_WE_D;
            h_me_we_q   <= ME_WE_D && (RD_D != 5'd0);
            h_mem_reg_q <= MEM_REG_D;
            h_rem_q     <= (ALU_OP == 4'd12);
        end else if ((state_q == S_BUSY) && !FLUSH) begin
            quo_q <= quo_n;
            rem_q <= rem_n;
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_out_q <= '0;
            wd_me_q   <= '0;
            rd_q      <= '0;
            mem_we_q  <= 1'b0;
            me_we_q   <= 1'b0;
            mem_reg_q <= 1'b0;
        end else begin
            alu_out_q <= alu_out_d;
            wd_me_q   <= wd_me_d;
            rd_q      <= rd_d;
            mem_we_q  <= mem_we_d;
            me_we_q   <= me_we_d;
            mem_reg_q <= mem_reg_d;
        end
    end

    assign ALU_OUT   = alu_out_q;
    assign WD_ME     = wd_me_q;
    assign RD        = rd_q;
    assign MEM_WE    = mem_we_q;
    assign ME_WE     = me_we_q;
    assign MEM_REG   = mem_reg_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed vector table, divider corner sequences and
// random transactions checked against an arithmetic reference model.
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] SRC_A, SRC_B, IMM, BP_MEM, BP_WB;
    logic        ALU_SRC, VALID_D, MEM_WE_D, ME_WE_D, MEM_REG_D, FLUSH;
    logic [3:0]  ALU_OP;
    logic [1:0]  FWD_A, FWD_B;
    logic [4:0]  RD_D;
    logic [31:0] ALU_OUT, WD_ME;
    logic [4:0]  RD;
    logic        MEM_WE, ME_WE, MEM_REG, STALL;
    logic [1:0]  DBG_STATE;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    execute_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .SRC_A(SRC_A), .SRC_B(SRC_B), .IMM(IMM),
        .ALU_SRC(ALU_SRC), .ALU_OP(ALU_OP), .FWD_A(FWD_A), .FWD_B(FWD_B),
        .BP_MEM(BP_MEM), .BP_WB(BP_WB), .VALID_D(VALID_D), .RD_D(RD_D),
        .MEM_WE_D(MEM_WE_D), .ME_WE_D(ME_WE_D), .MEM_REG_D(MEM_REG_D),
        .FLUSH(FLUSH), .ALU_OUT(ALU_OUT), .WD_ME(WD_ME), .RD(RD),
        .MEM_WE(MEM_WE), .ME_WE(ME_WE), .MEM_REG(MEM_REG), .STALL(STALL),
        .DBG_STATE(DBG_STATE)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, imm;
        logic        alu_src;
        logic [1:0]  fa, fb;
        logic [31:0] bm, bw;
        logic [4:0]  rd;
        logic        me_we, mem_we, mem_reg;
        logic [31:0] exp_alu;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sel(input logic [1:0] f, input logic [31:0] s,
                                        input logic [31:0] m, input logic [31:0] w);
        return (f == 2'b01) ? m : (f == 2'b10) ? w : s;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned s;
        s = b % 32;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << s;
            4'd6:  return a >> s;
            4'd7:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            4'd8:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return a * b;
            4'd11: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd12: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_opb(input vec_t v);
        return v.alu_src ? v.imm : sel(v.fb, v.b, v.bm, v.bw);
    endfunction

    task automatic drive(input vec_t v);
        ALU_OP = v.op; SRC_A = v.a; SRC_B = v.b; IMM = v.imm; ALU_SRC = v.alu_src;
        FWD_A = v.fa; FWD_B = v.fb; BP_MEM = v.bm; BP_WB = v.bw; RD_D = v.rd;
        ME_WE_D = v.me_we; MEM_WE_D = v.mem_we; MEM_REG_D = v.mem_reg;
        VALID_D = 1'b1; FLUSH = 1'b0;
    endtask

    // Runs the driven instruction to completion and checks the EX/MEM contents.
    task automatic complete(input vec_t v, input logic [31:0] exp_alu, input string tag);
        int n;
        logic bubble_bad;
        #1;
        if (v.op == 4'd11 || v.op == 4'd12) begin
            n = 0;
            bubble_bad = 1'b0;
            while (STALL === 1'b1 && n < 100) begin
                n++;
                step();
                if (n == 5) begin BP_MEM = $urandom; BP_WB = $urandom; end
                if ((ALU_OUT | WD_ME | {24'b0, RD, MEM_WE, ME_WE, MEM_REG}) !== 32'h0)
                    bubble_bad = 1'b1;
            end
            chk({tag, "_stall_cycles"}, n, 33);
            chk({tag, "_stall_bubble"}, {31'b0, bubble_bad}, 0);
        end else begin
            chk({tag, "_stall"}, {31'b0, STALL}, 0);
        end
        step();
        chk({tag, "_alu"}, ALU_OUT, exp_alu);
        chk({tag, "_wd"}, WD_ME, sel(v.fb, v.b, v.bm, v.bw));
        chk({tag, "_ctrl"}, {24'b0, RD, MEM_WE, ME_WE, MEM_REG},
            {24'b0, v.rd, v.mem_we, v.me_we && (v.rd != 0), v.mem_reg});
        VALID_D = 1'b0;
    endtask

    initial begin
        vec_t v;
        vecs[0]  = '{4'd0,  32'd5, 32'd0, 32'hFFFF_FFF9, 1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE};
        vecs[1]  = '{4'd1,  32'h99, 32'd1, 32'h0, 1'b0, 2'b01, 2'b00, 32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0F};
        vecs[2]  = '{4'd1,  32'h99, 32'd1, 32'h0, 1'b0, 2'b01, 2'b00, 32'h10, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0F};
        vecs[3]  = '{4'd7,  32'h8000_0000, 32'd4, 32'h0, 1'b0, 2'b00, 2'b11, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 32'hF800_0000};
        vecs[4]  = '{4'd8,  32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 32'd1};
        vecs[5]  = '{4'd9,  32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[6]  = '{4'd5,  32'd1, 32'h25, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd10, 1'b0, 1'b0, 1'b0, 32'h20};
        vecs[7]  = '{4'd10, 32'h1_0000, 32'h1_0000, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{4'd13, 32'h1234, 32'h5678, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{4'd11, 32'd100, 32'd7, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd13, 1'b1, 1'b0, 1'b0, 32'd14};
        vecs[10] = '{4'd12, 32'd100, 32'd7, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd14, 1'b1, 1'b0, 1'b0, 32'd2};
        vecs[11] = '{4'd11, 32'h1234, 32'd0, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd15, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF};
        vecs[12] = '{4'd12, 32'h1234, 32'd0, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd16, 1'b1, 1'b0, 1'b0, 32'h1234};
        vecs[13] = '{4'd2,  32'hFF, 32'h0, 32'h0, 1'b0, 2'b00, 2'b10, 32'h0, 32'h55, 5'd17, 1'b1, 1'b0, 1'b0, 32'h55};
        vecs[14] = '{4'd0,  32'h1000, 32'hABCD, 32'h8, 1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h1008};

        rst = 1'b0;
        drive(vecs[9]);
        #12;
        chk("reset_stall", {31'b0, STALL}, 0);
        chk("reset_outputs", ALU_OUT | WD_ME | {24'b0, RD, MEM_WE, ME_WE, MEM_REG}, 0);
        chk("reset_state", {30'b0, DBG_STATE}, 0);
        VALID_D = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("invalid_bubble", ALU_OUT | WD_ME | {24'b0, RD, MEM_WE, ME_WE, MEM_REG}, 0);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i]);
            complete(vecs[i], vecs[i].exp_alu, $sformatf("vec%0d", i));
        end

        // Flush in the middle of a divide, then a normal op.
        drive(vecs[9]);
        repeat (10) step();
        chk("flush_busy_stall", {31'b0, STALL}, 1);
        FLUSH = 1'b1;
        #1;
        chk("flush_stall", {31'b0, STALL}, 0);
        step();
        FLUSH = 1'b0;
        VALID_D = 1'b0;
        chk("flush_bubble", ALU_OUT | WD_ME | {24'b0, RD, MEM_WE, ME_WE, MEM_REG}, 0);
        chk("flush_state", {30'b0, DBG_STATE}, 0);
        drive(vecs[0]);
        complete(vecs[0], vecs[0].exp_alu, "post_flush");

        // Asynchronous reset mid-divide, then restart with the op held.
        drive(vecs[10]);
        repeat (15) step();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_stall", {31'b0, STALL}, 0);
        chk("arst_outputs", ALU_OUT | WD_ME | {24'b0, RD, MEM_WE, ME_WE, MEM_REG}, 0);
        chk("arst_state", {30'b0, DBG_STATE}, 0);
        step();
        step();
        rst = 1'b1;
        complete(vecs[10], vecs[10].exp_alu, "arst_restart");

        for (int i = 0; i < 200; i++) begin
            v.op = 4'($urandom_range(0, 15));
            if ((v.op == 4'd11 || v.op == 4'd12) && $urandom_range(0, 3) != 0)
                v.op = 4'($urandom_range(0, 10));
            v.a = $urandom;
            v.b = ($urandom_range(0, 7) == 0) ? 32'h0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 300)));
            v.imm = $urandom;
            v.alu_src = 1'($urandom_range(0, 1));
            v.fa = 2'($urandom_range(0, 3));
            v.fb = 2'($urandom_range(0, 3));
            v.bm = $urandom;
            v.bw = $urandom;
            v.rd = 5'($urandom_range(0, 31));
            v.me_we = 1'($urandom_range(0, 1));
            v.mem_we = 1'($urandom_range(0, 1));
            v.mem_reg = 1'($urandom_range(0, 1));
            v.exp_alu = ref_alu(v.op, sel(v.fa, v.a, v.bm, v.bw), ref_opb(v));
            drive(v);
            complete(v, v.exp_alu, $sformatf("rnd%0d_op%0d", i, v.op));
            if ($urandom_range(0, 3) == 0) step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
